// File: rtl/dmem_lsu_pkg.sv
// Shared opcodes, FSM states and decode helpers for the data-memory load/store unit.
package dmem_lsu_pkg;

  localparam logic [5:0] OPC_LB  = 6'h20;
  localparam logic [5:0] OPC_LH  = 6'h21;
  localparam logic [5:0] OPC_LW  = 6'h23;
  localparam logic [5:0] OPC_LBU = 6'h24;
  localparam logic [5:0] OPC_LHU = 6'h25;
  localparam logic [5:0] OPC_SB  = 6'h28;
  localparam logic [5:0] OPC_SH  = 6'h29;
  localparam logic [5:0] OPC_SW  = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    MOP_LB, MOP_LBU, MOP_LH, MOP_LHU, MOP_LW, MOP_SB, MOP_SH, MOP_SW
  } mop_e;

  typedef struct packed {
    logic valid;
    mop_e op;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] opc);
    dec_t d;
    d.valid = 1'b1;
    d.op    = MOP_LW;
    case (opc)
      OPC_LB:  d.op = MOP_LB;
      OPC_LBU: d.op = MOP_LBU;
      OPC_LH:  d.op = MOP_LH;
      OPC_LHU: d.op = MOP_LHU;
      OPC_LW:  d.op = MOP_LW;
      OPC_SB:  d.op = MOP_SB;
      OPC_SH:  d.op = MOP_SH;
      OPC_SW:  d.op = MOP_SW;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic is_load(input mop_e op);
    return (op == MOP_LB) || (op == MOP_LBU) || (op == MOP_LH) ||
           (op == MOP_LHU) || (op == MOP_LW);
  endfunction

  function automatic logic aligned(input mop_e op, input logic [1:0] off);
    case (op)
      MOP_LW, MOP_SW:          return off == 2'b00;
      MOP_LH, MOP_LHU, MOP_SH: return off[0] == 1'b0;
      default:                 return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Handshaked (req/ack) data-memory bus with byte enables; master = LSU, slave = memory.
interface dmem_lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be, mem_adr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_adr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dmem_lsu_lane.sv
// Byte-lane steering: store byte enables / replicated data and load extraction with extension.
module lsu_lane
  import dmem_lsu_pkg::*;
(
  input  mop_e        op,
  input  logic [1:0]  off,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rdata[{off, 3'b000} +: 8];
  assign rhalf = rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    be    = 4'hF;
    wdata = sdata;
    ldata = rdata;
    case (op)
      MOP_LB:  ldata = {{24{rbyte[7]}}, rbyte};
      MOP_LBU: ldata = {24'd0, rbyte};
      MOP_LH:  ldata = {{16{rhalf[15]}}, rhalf};
      MOP_LHU: ldata = {16'd0, rhalf};
      MOP_SB: begin
        be    = 4'b0001 << off;
        wdata = {4{sdata[7:0]}};
      end
      MOP_SH: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{sdata[15:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: issues one memory access at a time, stalls the core until ack or timeout.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int MAX_WAIT = 255
)(
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  output logic        Stall,
  output logic [31:0] LoadData,
  output logic        LoadValid,
  output logic        AdrErr,
  output logic        BusErr,
  dmem_lsu_if.master  mem
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  state_e           state_q, state_d;
  dec_t             dec;
  logic             addr_ok, issue, misalign, acked, timeout;
  logic [CNT_W-1:0] wait_q;

  mop_e             op_p1;
  logic [1:0]       off_p1;
  logic [29:0]      wadr_p1;
  logic [31:0]      sdata_p1;

  logic [3:0]       lane_be;
  logic [31:0]      lane_wdata, lane_ldata;
  logic             unused_ins;

  assign unused_ins = ^Ins[25:0];

  assign dec      = decode(Ins[31:26]);
  assign addr_ok  = aligned(dec.op, Result[1:0]);
  assign issue    = (state_q == ST_IDLE) && EN && dec.valid && addr_ok;
  assign misalign = (state_q == ST_IDLE) && EN && dec.valid && !addr_ok;
  assign acked    = (state_q == ST_REQ) && mem.mem_ack;
  // An ack arriving in the last allowed cycle still wins over the timeout.
  assign timeout  = (state_q == ST_REQ) && !mem.mem_ack && (wait_q == CNT_LAST);

  lsu_lane u_lane (
    .op    (op_p1),
    .off   (off_p1),
    .sdata (sdata_p1),
    .rdata (mem.mem_rdata),
    .be    (lane_be),
    .wdata (lane_wdata),
    .ldata (lane_ldata)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (issue) state_d = ST_REQ;
      ST_REQ: begin
        if (acked)        state_d = ST_DONE;
        else if (timeout) state_d = ST_IDLE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Issue stage: operands captured once; later core changes while stalled are ignored.
  always_ff @(posedge CLK) begin
    if (issue) begin
      op_p1    <= dec.op;
      off_p1   <= Result[1:0];
      wadr_p1  <= Result[31:2];
      sdata_p1 <= Rdata2;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_q   <= '0;
      AdrErr   <= 1'b0;
      BusErr   <= 1'b0;
      LoadData <= '0;
    end else begin
      AdrErr <= misalign;
      BusErr <= timeout;
      if ((state_q == ST_REQ) && !acked && !timeout) wait_q <= wait_q + 1'b1;
      else                                           wait_q <= '0;
      if (acked && is_load(op_p1)) LoadData <= lane_ldata;
    end
  end

  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_be    = 4'h0;
    mem.mem_adr   = 32'd0;
    mem.mem_wdata = 32'd0;
    LoadValid     = 1'b0;
    Stall         = issue;
    case (state_q)
      ST_REQ: begin
        Stall         = 1'b1;
        mem.mem_req   = 1'b1;
        mem.mem_we    = !is_load(op_p1);
        mem.mem_be    = lane_be;
        mem.mem_adr   = {2'b00, wadr_p1};
        mem.mem_wdata = is_load(op_p1) ? 32'd0 : lane_wdata;
      end
      ST_DONE: LoadValid = is_load(op_p1);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized bench for dmem_lsu: transaction-timeline model plus literal anchor checks.
module tb_dmem_lsu;

  localparam int MW = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN = 1'b0;
  logic [31:0] Ins = '0, Result = '0, Rdata2 = '0;
  logic        Stall, LoadValid, AdrErr, BusErr;
  logic [31:0] LoadData;

  dmem_lsu_if mif();

  dmem_lsu #(.MAX_WAIT(MW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .Ins       (Ins),
    .Result    (Result),
    .Rdata2    (Rdata2),
    .Stall     (Stall),
    .LoadData  (LoadData),
    .LoadValid (LoadValid),
    .AdrErr    (AdrErr),
    .BusErr    (BusErr),
    .mem       (mif)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic        exp_stall, exp_req, exp_we, exp_lv, exp_adrerr, exp_buserr;
  logic [3:0]  exp_be;
  logic [31:0] exp_adr, exp_wdata, exp_ld;
  logic [31:0] ld_m = '0;

  int          req_cycles = 0;
  int          bus_pulses = 0;
  logic [31:0] cap_adr = '0, cap_wdata = '0;
  logic [3:0]  cap_be = '0;
  logic        cap_we = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, req);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("Stall",     32'(Stall),       32'(exp_stall));
      chk("mem_req",   32'(mif.mem_req), 32'(exp_req));
      chk("LoadValid", 32'(LoadValid),   32'(exp_lv));
      chk("AdrErr",    32'(AdrErr),      32'(exp_adrerr));
      chk("BusErr",    32'(BusErr),      32'(exp_buserr));
      chk("LoadData",  LoadData,         exp_ld);
      if (exp_req) begin
        chk("mem_we",  32'(mif.mem_we), 32'(exp_we));
        chk("mem_be",  32'(mif.mem_be), 32'(exp_be));
        chk("mem_adr", mif.mem_adr,     exp_adr);
        if (exp_we) chk("mem_wdata", mif.mem_wdata, exp_wdata);
      end
      if (mif.mem_req) begin
        req_cycles++;
        cap_adr   = mif.mem_adr;
        cap_be    = mif.mem_be;
        cap_we    = mif.mem_we;
        cap_wdata = mif.mem_wdata;
      end
      if (BusErr) bus_pulses++;
    end
  end

  function automatic void op_info(input logic [5:0] opc, output bit valid, output int size,
                                  output bit sgn, output bit load);
    valid = 1'b1; size = 4; sgn = 1'b0; load = 1'b1;
    case (opc)
      6'h23: begin size = 4; end
      6'h21: begin size = 2; sgn = 1'b1; end
      6'h25: begin size = 2; end
      6'h20: begin size = 1; sgn = 1'b1; end
      6'h24: begin size = 1; end
      6'h2B: begin size = 4; load = 1'b0; end
      6'h29: begin size = 2; load = 1'b0; end
      6'h28: begin size = 1; load = 1'b0; end
      default: valid = 1'b0;
    endcase
  endfunction

  // Advance to just after the next rising edge; default: no ack, nothing expected.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    mif.mem_ack = 1'b0;
    mif.mem_rdata = $urandom;
    exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_lv = 1'b0;
    exp_adrerr = 1'b0; exp_buserr = 1'b0;
    exp_be = '0; exp_adr = '0; exp_wdata = '0; exp_ld = ld_m;
  endtask

  task automatic full_noise();
    EN = 1'($urandom);
    Ins = $urandom;
    Result = $urandom;
    Rdata2 = $urandom;
  endtask

  task automatic idle_noise();
    bit v, s, l;
    int sz;
    full_noise();
    op_info(Ins[31:26], v, sz, s, l);
    if (v) EN = 1'b0;
  endtask

  // d = cycle after issue on which ack arrives (1..MW); d = 0 means memory never answers.
  task automatic do_op(input logic [5:0] opc, input logic [31:0] res, input logic [31:0] rd2,
                       input logic [31:0] rdata, input int d);
    bit v, sgn, load, ok;
    int size, n;
    logic [1:0]  off;
    logic [3:0]  be_m;
    logic [31:0] wd_m, ext;
    op_info(opc, v, size, sgn, load);
    off  = res[1:0];
    ok   = (int'(off) % size) == 0;
    be_m = load ? 4'hF : 4'(((1 << size) - 1) << off);
    wd_m = (size == 4) ? rd2 : (size == 2) ? rd2[15:0] * 32'h0001_0001 : rd2[7:0] * 32'h0101_0101;
    ext  = rdata >> (8 * int'(off));
    if (size == 1) begin
      ext = ext & 32'hFF;
      if (sgn && ext[7]) ext = ext | 32'hFFFF_FF00;
    end else if (size == 2) begin
      ext = ext & 32'hFFFF;
      if (sgn && ext[15]) ext = ext | 32'hFFFF_0000;
    end

    next_cycle();
    EN = 1'b1; Ins = {opc, 26'($urandom)}; Result = res; Rdata2 = rd2;
    mif.mem_ack = 1'($urandom);
    exp_stall = ok;
    if (!ok) begin
      next_cycle();
      idle_noise();
      exp_adrerr = 1'b1;
      return;
    end

    n = (d == 0) ? MW : d;
    for (int k = 1; k <= n; k++) begin
      next_cycle();
      full_noise();
      mif.mem_ack = (k == d);
      if (k == d) mif.mem_rdata = rdata;
      exp_stall = 1'b1; exp_req = 1'b1; exp_we = !load; exp_be = be_m;
      exp_adr = {2'b00, res[31:2]}; exp_wdata = wd_m;
    end

    if (d == 0) begin
      next_cycle();
      idle_noise();
      mif.mem_ack = 1'b1;
      exp_buserr = 1'b1;
      next_cycle();
      idle_noise();
      mif.mem_ack = 1'b1;
      return;
    end

    if (load) ld_m = ext;
    next_cycle();
    full_noise();
    mif.mem_ack = 1'($urandom);
    exp_lv = load;
  endtask

  task automatic reset_mid();
    logic [31:0] a;
    a = {$urandom, 2'b00} & 32'hFFFF_FFFC;
    next_cycle();
    EN = 1'b1; Ins = {6'h23, 26'($urandom)}; Result = a;
    exp_stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      full_noise();
      if (k == 1) RST = 1'b1;
      exp_stall = 1'b1; exp_req = 1'b1; exp_we = 1'b0; exp_be = 4'hF;
      exp_adr = {2'b00, a[31:2]};
    end
    ld_m = '0;
    next_cycle();
    EN = 1'b0;
  endtask

  logic [5:0] opcs [8] = '{6'h23, 6'h21, 6'h25, 6'h20, 6'h24, 6'h2B, 6'h29, 6'h28};
  int r0, b0;

  initial begin
    mif.mem_ack = 1'b0;
    mif.mem_rdata = '0;
    @(posedge CLK);
    next_cycle();
    RST = 1'b1;
    chk_en = 1'b1;

    // SW store, two-cycle memory latency
    do_op(6'h2B, 32'd8, 32'hDEAD_BEEF, 32'd0, 2);
    @(negedge CLK);
    chk("t1_adr",   cap_adr,        32'd2);
    chk("t1_be",    32'(cap_be),    32'hF);
    chk("t1_we",    32'(cap_we),    32'd1);
    chk("t1_wdata", cap_wdata,      32'hDEAD_BEEF);

    do_op(6'h20, 32'd5, $urandom, 32'h1122_8033, 1);
    @(negedge CLK);
    chk("t2_lb_data",  LoadData,       32'hFFFF_FF80);
    chk("t2_lb_valid", 32'(LoadValid), 32'd1);
    do_op(6'h24, 32'd5, $urandom, 32'h1122_8033, 1);
    @(negedge CLK);
    chk("t2_lbu_data", LoadData, 32'h0000_0080);

    do_op(6'h29, 32'd6, 32'h0000_ABCD, 32'd0, $urandom_range(1, MW));
    @(negedge CLK);
    chk("t3_sh_be",    32'(cap_be), 32'hC);
    chk("t3_sh_wdata", cap_wdata,   32'hABCD_ABCD);
    do_op(6'h25, 32'd2, $urandom, 32'h1234_5678, 1);
    @(negedge CLK);
    chk("t3_lhu_data", LoadData, 32'h0000_1234);

    r0 = req_cycles;
    do_op(6'h23, 32'd2, $urandom, $urandom, 1);
    @(negedge CLK);
    chk("t4_lw_adrerr", 32'(AdrErr), 32'd1);
    do_op(6'h21, 32'd3, $urandom, $urandom, 1);
    @(negedge CLK);
    chk("t4_lh_adrerr", 32'(AdrErr),            32'd1);
    chk("t4_no_req",    32'(req_cycles - r0),   32'd0);

    r0 = req_cycles;
    b0 = bus_pulses;
    do_op(6'h23, 32'h40, $urandom, $urandom, 0);
    @(negedge CLK);
    chk("t5_req_cycles", 32'(req_cycles - r0), 32'd4);
    chk("t5_buserr",     32'(bus_pulses - b0), 32'd1);

    reset_mid();
    do_op(6'h23, 32'd0, $urandom, 32'hCAFE_F00D, 2);
    @(negedge CLK);
    chk("t6_lw_after_rst", LoadData, 32'hCAFE_F00D);

    for (int i = 0; i < 300; i++) begin
      int d;
      d = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, MW);
      if ($urandom_range(0, 29) == 0) reset_mid();
      do_op(opcs[$urandom_range(0, 7)], $urandom, $urandom, $urandom, d);
      repeat ($urandom_range(0, 2)) begin
        next_cycle();
        idle_noise();
        mif.mem_ack = 1'($urandom);
      end
    end

    next_cycle();
    EN = 1'b0;
    @(negedge CLK);
    #1;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
